// File: rtl/mem_copy_pkg.sv
// Shared widths and FSM state type for the word-copy DMA.
package mem_copy_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;
  localparam int IDX_W  = 12;
  localparam int LEN_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/mem_copy_dma.sv
// Single-port memory copy engine: one read then one write per word,
// ascending order, addresses wrap modulo DEPTH.
module mem_copy_dma #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_pkg::DATA_W,
  parameter int DEPTH  = mem_copy_pkg::DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              src_addr,
  input  logic [ADDR_W-1:0]              dst_addr,
  input  logic [mem_copy_pkg::LEN_W-1:0] length,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_in,
  output logic                           mem_load,
  input  logic [DATA_W-1:0]              mem_out
);
  import mem_copy_pkg::*;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   addr_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    data_d   = data_q;
    busy     = 1'b0;
    done     = 1'b0;
    mem_load = 1'b0;
    addr_lo  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr[IDX_W-1:0];
          dst_d = dst_addr[IDX_W-1:0];
          len_d = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
          i_d   = '0;
          state_d = (length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        addr_lo = src_q + i_q;
        data_d  = mem_out;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_load = 1'b1;
        addr_lo  = dst_q + i_q;
        i_d      = i_q + IDX_W'(1);
        // i is one short of LEN_W, so compare in the wider width
        state_d  = ({1'b0, i_q} + LEN_W'(1) == len_q) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address = {{(ADDR_W-IDX_W){1'b0}}, addr_lo};
  assign mem_in      = data_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural memory, table of copies,
// random copies, all checked against a sequential copy model.
module tb_mem_copy_dma;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src_addr, dst_addr;
  logic [12:0] length;
  logic        busy, done, mem_load;
  logic [15:0] mem_address, mem_in, mem_out;

  logic [15:0] M [0:4095];
  logic [15:0] R [0:4095];
  logic        pl_init, pl_we;
  logic [11:0] pl_a;
  logic [15:0] pl_d;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address),
    .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  assign mem_out = M[mem_address[11:0]];

  always @(posedge clk) begin
    if (pl_init) begin
      for (int k = 0; k < 4096; k++) M[k] <= 16'(k) ^ 16'hA5A5;
    end else if (mem_load) begin
      M[mem_address[11:0]] <= mem_in;
    end else if (pl_we) begin
      M[pl_a] <= pl_d;
    end
  end

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [12:0] len;
    int          int_c;
    int          rst_c;
    int          ex_busy;
    int          ex_done;
    int          ex_wr;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
    R[a] = d;
  endtask

  task automatic run_copy(input vec_t v);
    int n, k, busy_n, wr_n, done_c, done_n, hi_n, both_n, lim, diff;
    logic [11:0] sa, da;
    busy_n = 0; wr_n = 0; done_c = -1; done_n = 0;
    hi_n = 0; both_n = 0; diff = 0;
    n = (v.len > 13'd4096) ? 4096 : int'(v.len);
    lim = (v.rst_c > 0) ? v.rst_c : 2 * n + 4;
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; length = v.len; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      start = (c == v.int_c);
      if (start) src_addr = 16'h0300;
      if (c == v.rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_load", mem_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_min", mem_in, 0);
        repeat (3) begin
          @(negedge clk);
          if (done) done_n++;
          if (mem_load) wr_n++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (mem_load) wr_n++;
      if (mem_address[15:12] != 4'd0) hi_n++;
      if (busy && done) both_n++;
    end
    start = 1'b0;
    chk("busy_cycles", busy_n, v.ex_busy);
    chk("done_cycle", done_c, v.ex_done);
    chk("done_pulses", done_n, (v.rst_c > 0) ? 0 : 1);
    chk("writes", wr_n, v.ex_wr);
    chk("addr_hi", hi_n, 0);
    chk("busy_and_done", both_n, 0);
    k = (v.rst_c > 0) ? (v.rst_c - 1) / 2 : n;
    for (int j = 0; j < k; j++) begin
      sa = v.src[11:0] + 12'(j);
      da = v.dst[11:0] + 12'(j);
      R[da] = R[sa];
    end
    for (int j = 0; j < 4096; j++) if (M[j] !== R[j]) diff++;
    chk("mem_image", diff, 0);
  endtask

  vec_t tbl [8];
  vec_t rv;
  int   rn;

  initial begin
    tbl[0] = '{16'h0010, 16'h0800, 13'd4,    0, 0, 8,    9,    4};
    tbl[1] = '{16'h0050, 16'h0060, 13'd0,    0, 0, 0,    1,    0};
    tbl[2] = '{16'h0FFE, 16'h0100, 13'd4,    0, 0, 8,    9,    4};
    tbl[3] = '{16'h0200, 16'h0201, 13'd3,    0, 0, 6,    7,    3};
    tbl[4] = '{16'h0400, 16'h0500, 13'd4,    3, 0, 8,    9,    4};
    tbl[5] = '{16'h0600, 16'h0700, 13'd8,    0, 6, 5,    -1,   2};
    tbl[6] = '{16'hF005, 16'h7400, 13'd2,    0, 0, 4,    5,    2};
    tbl[7] = '{16'h0123, 16'h0923, 13'd5000, 0, 0, 8192, 8193, 4096};

    rst_n = 1'b0; start = 1'b0; pl_init = 1'b1; pl_we = 1'b0;
    pl_a = '0; pl_d = '0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int k = 0; k < 4096; k++) R[k] = 16'(k) ^ 16'hA5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pl_init = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_load", mem_load, 0);
    chk("reset_addr", mem_address, 0);
    chk("reset_min", mem_in, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 3) poke(12'h200, 16'd7);
      run_copy(tbl[i]);
      if (i == 0) chk("basic_803", M[12'h803], 16'h0013 ^ 16'hA5A5);
      if (i == 2) begin
        chk("wrap_100", M[12'h100], 16'h0FFE ^ 16'hA5A5);
        chk("wrap_102", M[12'h102], 16'h0000 ^ 16'hA5A5);
      end
      if (i == 3) begin
        chk("ovl_201", M[12'h201], 7);
        chk("ovl_203", M[12'h203], 7);
      end
    end

    for (int r = 0; r < 12; r++) begin
      rn = int'($urandom_range(0, 40));
      rv.src = 16'($urandom);
      rv.dst = 16'($urandom);
      rv.len = 13'(rn);
      rv.int_c = (r % 3 == 0) ? 2 : 0;
      rv.rst_c = 0;
      rv.ex_busy = 2 * rn;
      rv.ex_done = 2 * rn + 1;
      rv.ex_wr = rn;
      run_copy(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory word width.
- DEPTH, 4096, words in the target memory.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  copy request; sampled only in IDLE.
- src_addr  input  16  first source word address.
- dst_addr  input  16  first destination word address.
- length  input  13  word count, 0..4096.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle completion pulse.
- mem_address  output  16  memory address.
- mem_in  output  16  memory write data.
- mem_load  output  1  memory write enable.
- mem_out  input  16  memory read data; combinational from mem_address.
REQ-003 The block SHALL be the initiator side of a single-port memory: combinational read, write on the rising clk edge while mem_load=1.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-005 IDLE with start=1 SHALL capture src_addr, dst_addr and length, and clear the word index i to 0.
REQ-006 From IDLE with start=1, the next state SHALL be READ if length>0, otherwise DONE.
REQ-007 READ SHALL drive mem_address={4'b0,(src+i) mod 4096} with mem_load=0; on the clock edge it SHALL register mem_out into data_q, then go to WRITE.
REQ-008 WRITE SHALL drive mem_address={4'b0,(dst+i) mod 4096}, mem_in=data_q and mem_load=1.
REQ-009 At the end of WRITE, i SHALL increment; the next state SHALL be DONE if i+1==length, otherwise READ.
REQ-010 DONE SHALL assert done=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-011 start SHALL be ignored in READ, WRITE and DONE; captured parameters SHALL NOT change mid-copy.
REQ-012 Address arithmetic SHALL be modulo 4096, so the low 12 bits wrap from 4095 to 0; mem_address[15:12] SHALL always be 0; src_addr/dst_addr bits [15:12] SHALL be ignored.
REQ-013 length values above 4096 SHALL be saturated to 4096 at capture.
REQ-014 Copy order SHALL be ascending word-by-word, one read then one write per word. Overlapping regions SHALL produce exactly that sequential result; no overlap detection.
REQ-015 Latency: with start accepted at edge t, the last write SHALL occur at edge t+2N and done SHALL be high in cycle t+2N+1; for N=0, done SHALL be high in cycle t+1 and no write SHALL occur.
REQ-016 Outside READ/WRITE, mem_address SHALL be 0 and mem_load SHALL be 0; mem_in SHALL always equal data_q.
REQ-017 busy SHALL be 0 in IDLE and DONE; busy and done SHALL never both be 1.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
- state=IDLE;
- i, data_q, captured src, dst and length = 0;
- busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
REQ-019 Reset during a copy SHALL abort it immediately with no further writes; words already written SHALL remain in memory, and no done pulse SHALL be produced.
REQ-020 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-021 A shared package mem_copy_pkg SHALL hold ADDR_W, DATA_W, DEPTH, the 12-bit index width, and the state enum type.
REQ-022 The block SHALL be a single module with no sub-module; FSM, index counter and data register SHALL all reside in mem_copy_dma.

Verification
REQ-023 The bench SHALL connect a 4096-word behavioural memory (combinational read, synchronous write, preloaded M[k]=k^16'hA5A5) and cover these scenarios:
- Basic copy: src=0x010, dst=0x800, length=4 -> M[0x800..0x803]=M[0x010..0x013]; busy high 8 cycles; done in cycle t+9.
- Zero length: length=0 -> no mem_load pulse; done in cycle t+1; busy never asserted.
- Wrap-around: src=0xFFE, dst=0x100, length=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 are copied to 0x100..0x103; mem_address[15:12]=0 throughout.
- Overlap: src=0x200, dst=0x201, length=3, with M[0x200]=7 -> M[0x201..0x203]=7.
- Start while busy: second start pulse (src=0x300) mid-copy -> ignored; only the first copy's writes occur; exactly one done pulse.
- Reset mid-copy: rst_n low during the third WRITE of a length=8 copy -> mem_load drops immediately; exactly 2 destination words are written; no done; a new copy afterwards completes normally.
